inst_prefetch_queue: RTL and testbench

//  Instruction prefetch queue in front of the IF stage. Streams sequential fetch

---
 rtl/inst_prefetch_queue.sv | 82 ++++++++
 tb/tb_inst_prefetch_queue.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential fetch streamer with a credit-limited {pc, instr} FIFO feeding IF.
// A redirect flushes the queue and any in-flight response, then refetches from the target.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          push, pop, credit;

    // Outstanding request counts against capacity so a returning response always has a slot.
    assign credit    = ({1'b0, count_q} + {{(AW + 1){1'b0}}, pending_q}) < (AW + 2)'(DEPTH);
    assign imem_req  = rst & ~redirect & credit;
    assign imem_addr = fetch_pc_q;
    assign out_valid = count_q != '0;
    assign push      = pending_q & ~redirect;
    assign pop       = out_valid & out_ready;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : hold_pc_q;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : hold_instr_q;
    assign count     = count_q;

    always_comb begin
        fetch_pc_d   = redirect ? {redirect_pc[31:2], 2'b00} : (imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q);
        pending_d    = imem_req;
        pend_pc_d    = imem_req ? fetch_pc_q : pend_pc_q;
        wr_ptr_d     = redirect ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d     = redirect ? '0 : rd_ptr_q + AW'(pop);
        count_d      = redirect ? '0 : count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        hold_pc_d    = out_pc;
        hold_instr_d = out_instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            pending_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pend_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: randomized and directed checks of the prefetch queue
// against a transaction-level queue model.
module tb_inst_prefetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, redirect, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc, out_instr;
    logic [2:0]  count;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_instr;
    logic [31:0] w_rdata = 32'h0;
    logic [2:0]  w_count;

    int          n_cmp = 0;
    int          n_err = 0;
    ent_t        fifo[$];
    logic [31:0] infl[$];
    logic [31:0] m_fetch, m_last_pc, m_last_instr;
    logic        s_valid, s_req;
    logic [31:0] s_pc;
    logic [2:0]  s_count;
    int          w_n = 0;
    logic [31:0] w_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 32'h100 : $urandom;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_pc(32'h0), .out_valid(w_valid), .out_ready(1'b1),
        .out_pc(w_pc), .out_instr(w_instr), .count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Asserts reset off-edge, checks the cleared state before any clock, releases on a negedge.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        fifo.delete();
        infl.delete();
        m_fetch = 32'h0;
        m_last_pc = 32'h0;
        m_last_instr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, compare just after, advance the model, wait for next negedge.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic exp_req;
        redirect = rd;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        exp_req = !rd && (fifo.size() + infl.size() < DEPTH);
        chk("req", imem_req, exp_req);
        if (exp_req) chk("addr", imem_addr, m_fetch);
        chk("count", count, fifo.size());
        chk("valid", out_valid, fifo.size() != 0);
        if (fifo.size() != 0) begin
            m_last_pc = fifo[0].pc;
            m_last_instr = fifo[0].instr;
        end
        chk("out_pc", out_pc, m_last_pc);
        chk("out_instr", out_instr, m_last_instr);
        s_valid = out_valid;
        s_pc = out_pc;
        s_count = count;
        s_req = imem_req;
        if (w_req && w_n < 4) begin
            chk("wrap_addr", w_addr, w_exp[w_n]);
            w_n++;
        end
        if (rd) begin
            fifo.delete();
            infl.delete();
            m_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (fifo.size() != 0 && rdy) void'(fifo.pop_front());
            if (infl.size() != 0) fifo.push_back('{pc: infl[0], instr: infl[0] + 32'h100});
            infl.delete();
            if (exp_req) begin
                infl.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        int k;
        for (k = 1; k <= 8; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid) break;
        end
        chk({tag, "_lat"}, k, 3);
        chk({tag, "_pc"}, s_pc, exp_pc);
    endtask

    initial begin
        redirect = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        apply_reset();
        repeat (20) cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_seen", w_n, 4);
        repeat (10) cycle(1'b0, 32'h0, 1'b0);
        chk("full_count", s_count, DEPTH);
        chk("full_req", s_req, 0);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0043, 1'b0);
        wait_valid("redir", 32'h40);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h80, 1'b1);
        cycle(1'b1, 32'hC0, 1'b1);
        wait_valid("dbl_redir", 32'hC0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        #3;
        apply_reset();
        wait_valid("post_rst", 32'h0);
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 8) == 0, $urandom, ($urandom % 4) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
